// File: rtl/axi_slave_arbiter_if.sv
// Request/handshake inputs and registered grant outputs of one slave's arbiter.
// The slave modport is the arbiter side; the master modport is the interconnect side.
interface axi_slave_arbiter_if #(
  parameter int NUM_REQ  = 3,
  parameter int REQ_BITS = 2
);
  logic [NUM_REQ-1:0]  ar_req;
  logic [NUM_REQ-1:0]  aw_req;
  logic                ar_hs;
  logic                aw_hs;
  logic                r_last_hs;
  logic                b_hs;
  logic                grant_valid;
  logic [REQ_BITS-1:0] grant_id;
  logic                grant_write;
  logic                addr_phase;
  logic                data_phase;
  logic                err_timeout;

  modport slave (
    input  ar_req, aw_req, ar_hs, aw_hs, r_last_hs, b_hs,
    output grant_valid, grant_id, grant_write, addr_phase, data_phase, err_timeout
  );

  modport master (
    output ar_req, aw_req, ar_hs, aw_hs, r_last_hs, b_hs,
    input  grant_valid, grant_id, grant_write, addr_phase, data_phase, err_timeout
  );
endinterface

// File: rtl/axi_slave_arbiter.sv
// Per-slave round-robin arbiter with a registered transaction lock held from
// the address phase until the final R beat or the B handshake.
module axi_slave_arbiter #(
  parameter int NUM_REQ  = 3,
  parameter int REQ_BITS = 2,
  parameter int TIMEOUT  = 1023
) (
  input logic              clk,
  input logic              rstn,
  axi_slave_arbiter_if.slave bus
);

  localparam int CNT_BITS = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t              state;
  logic [REQ_BITS-1:0] ptr;
  logic [CNT_BITS-1:0] cnt;
  logic [NUM_REQ-1:0]  wf;

  logic [2*NUM_REQ-1:0] ar_rot;
  logic [2*NUM_REQ-1:0] aw_rot;
  logic [2*NUM_REQ-1:0] wf_rot;

  logic                found;
  logic [REQ_BITS-1:0] offset;
  logic                sel_ar;
  logic                sel_aw;
  logic                sel_wf;
  logic [REQ_BITS-1:0] winner;
  logic [REQ_BITS-1:0] ptr_next;
  logic                pick_write;
  logic                both_sel;
  logic                addr_done;
  logic                data_done;

  function automatic logic [REQ_BITS-1:0] mod_add(input logic [REQ_BITS-1:0] a,
                                                  input logic [REQ_BITS-1:0] b);
    logic [REQ_BITS:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= (REQ_BITS+1)'(NUM_REQ)) s = s - (REQ_BITS+1)'(NUM_REQ);
    return s[REQ_BITS-1:0];
  endfunction

  // Rotating by ptr turns the round-robin scan into a plain lowest-bit-first search.
  assign ar_rot = {bus.ar_req, bus.ar_req} >> ptr;
  assign aw_rot = {bus.aw_req, bus.aw_req} >> ptr;
  assign wf_rot = {wf, wf} >> ptr;

  always_comb begin
    found  = 1'b0;
    offset = '0;
    sel_ar = 1'b0;
    sel_aw = 1'b0;
    sel_wf = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && (ar_rot[k] || aw_rot[k])) begin
        found  = 1'b1;
        offset = REQ_BITS'(k);
        sel_ar = ar_rot[k];
        sel_aw = aw_rot[k];
        sel_wf = wf_rot[k];
      end
    end
  end

  assign winner     = mod_add(ptr, offset);
  assign ptr_next   = mod_add(winner, REQ_BITS'(1));
  assign both_sel   = sel_ar && sel_aw;
  assign pick_write = sel_aw && (!sel_ar || sel_wf);
  assign addr_done  = bus.grant_write ? bus.aw_hs : bus.ar_hs;
  assign data_done  = bus.grant_write ? bus.b_hs  : bus.r_last_hs;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state           <= IDLE;
      ptr             <= '0;
      cnt             <= '0;
      wf              <= '1;
      bus.grant_valid <= 1'b0;
      bus.grant_id    <= '0;
      bus.grant_write <= 1'b0;
      bus.addr_phase  <= 1'b0;
      bus.data_phase  <= 1'b0;
      bus.err_timeout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            state           <= ADDR;
            ptr             <= ptr_next;
            cnt             <= '0;
            bus.grant_valid <= 1'b1;
            bus.grant_id    <= winner;
            bus.grant_write <= pick_write;
            bus.addr_phase  <= 1'b1;
            bus.data_phase  <= 1'b0;
            for (int i = 0; i < NUM_REQ; i++) begin
              if (both_sel && (winner == REQ_BITS'(i))) wf[i] <= ~wf[i];
            end
          end
        end
        ADDR: begin
          if (addr_done) begin
            state          <= DATA;
            bus.addr_phase <= 1'b0;
            bus.data_phase <= 1'b1;
          end
        end
        DATA: begin
          if (data_done) begin
            state           <= IDLE;
            bus.grant_valid <= 1'b0;
            bus.grant_id    <= '0;
            bus.grant_write <= 1'b0;
            bus.data_phase  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase

      // The timeout only flags a stuck lock; it never releases the grant.
      if (state != IDLE) begin
        if (cnt != CNT_BITS'(TIMEOUT)) cnt <= cnt + 1'b1;
        if (cnt >= CNT_BITS'(TIMEOUT - 1)) bus.err_timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_axi_slave_arbiter.sv
// Directed bench for axi_slave_arbiter: expected grants go into a scoreboard
// queue that a negedge monitor pops whenever a new address phase begins.
module tb_axi_slave_arbiter;

  typedef struct {
    logic [1:0] id;
    logic       write;
  } exp_t;

  logic clk;
  logic rstn;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  logic prev_addr = 1'b0;

  axi_slave_arbiter_if #(.NUM_REQ(3), .REQ_BITS(2)) bus ();

  axi_slave_arbiter #(.NUM_REQ(3), .REQ_BITS(2), .TIMEOUT(8)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Each call defines the inputs seen at exactly one rising edge.
  task automatic applyStimulus(input logic [2:0] ar, input logic [2:0] aw,
                               input logic arhs, input logic awhs,
                               input logic rlast, input logic bhs);
    bus.ar_req    = ar;
    bus.aw_req    = aw;
    bus.ar_hs     = arhs;
    bus.aw_hs     = awhs;
    bus.r_last_hs = rlast;
    bus.b_hs      = bhs;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic expectGrant(input logic [1:0] id, input logic write);
    exp_t e;
    e.id    = id;
    e.write = write;
    exp_q.push_back(e);
  endtask

  task automatic simpleLock(input logic [2:0] ar, input logic [2:0] aw,
                            input logic wr, input logic [1:0] id);
    expectGrant(id, wr);
    applyStimulus(ar, aw, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("grant_valid_after_req", bus.grant_valid, 1);
    checkOutput("addr_phase_after_req", bus.addr_phase, 1);
    applyStimulus(ar, aw, !wr, wr, 1'b0, 1'b0);
    checkOutput("data_phase_after_addr_hs", bus.data_phase, 1);
    checkOutput("grant_id_in_data", bus.grant_id, id);
    checkOutput("grant_write_in_data", bus.grant_write, wr);
    applyStimulus(ar, aw, 1'b0, 1'b0, !wr, wr);
    checkOutput("grant_valid_after_done", bus.grant_valid, 0);
  endtask

  task automatic dirLock(input logic wr);
    expectGrant(2'd2, wr);
    applyStimulus(3'b100, 3'b100, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("dir_addr_phase", bus.addr_phase, 1);
    applyStimulus(3'b100, 3'b100, wr, !wr, 1'b1, 1'b1);
    checkOutput("dir_wrong_addr_hs_ignored", bus.addr_phase, 1);
    applyStimulus(3'b100, 3'b100, !wr, wr, 1'b0, 1'b0);
    checkOutput("dir_data_phase", bus.data_phase, 1);
    applyStimulus(3'b100, 3'b100, 1'b1, 1'b1, wr, !wr);
    checkOutput("dir_wrong_done_ignored", bus.data_phase, 1);
    applyStimulus(3'b100, 3'b100, 1'b0, 1'b0, !wr, wr);
    checkOutput("dir_released", bus.grant_valid, 0);
  endtask

  // A rising addr_phase marks a fresh grant; compare it with the oldest expectation.
  always @(negedge clk) begin
    if (bus.addr_phase && !prev_addr) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_grant: got id=%0d write=%0b, expected no grant",
                 bus.grant_id, bus.grant_write);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (bus.grant_id !== e.id || bus.grant_write !== e.write) begin
          errors++;
          $display("[TB] FAIL grant_scoreboard: got id=%0d write=%0b, expected id=%0d write=%0b",
                   bus.grant_id, bus.grant_write, e.id, e.write);
        end
      end
    end
    prev_addr = bus.addr_phase;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rstn = 1'b0;
    applyStimulus(3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(3'b111, 3'b111, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("reset_grant_valid", bus.grant_valid, 0);
    checkOutput("reset_addr_phase", bus.addr_phase, 0);
    checkOutput("reset_data_phase", bus.data_phase, 0);
    checkOutput("reset_grant_id", bus.grant_id, 0);
    checkOutput("reset_grant_write", bus.grant_write, 0);
    checkOutput("reset_err_timeout", bus.err_timeout, 0);
    rstn = 1'b1;

    $display("[TB] single read from master 1");
    simpleLock(3'b010, 3'b000, 1'b0, 2'd1);

    // ptr now 2, so 3'b101 must go to master 2 rather than master 0.
    $display("[TB] pointer advanced past master 1");
    simpleLock(3'b101, 3'b000, 1'b0, 2'd2);

    $display("[TB] round-robin with all masters requesting");
    simpleLock(3'b111, 3'b000, 1'b0, 2'd0);
    simpleLock(3'b111, 3'b000, 1'b0, 2'd1);
    simpleLock(3'b111, 3'b000, 1'b0, 2'd2);
    simpleLock(3'b111, 3'b000, 1'b0, 2'd0);

    $display("[TB] master 2 requesting both directions");
    dirLock(1'b1);
    dirLock(1'b0);
    dirLock(1'b1);

    $display("[TB] four-beat read burst");
    expectGrant(2'd2, 1'b0);
    applyStimulus(3'b100, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(3'b100, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int b = 0; b < 3; b++) begin
      applyStimulus(3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("burst_lock_held", bus.grant_valid, 1);
      checkOutput("burst_data_phase", bus.data_phase, 1);
    end
    applyStimulus(3'b000, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("burst_released", bus.grant_valid, 0);
    checkOutput("burst_no_timeout", bus.err_timeout, 0);

    $display("[TB] stuck write address phase");
    expectGrant(2'd0, 1'b1);
    applyStimulus(3'b000, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      applyStimulus(3'b000, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0);
      if (k == 7) checkOutput("timeout_not_yet", bus.err_timeout, 0);
    end
    checkOutput("timeout_set", bus.err_timeout, 1);
    checkOutput("timeout_lock_held", bus.grant_valid, 1);
    checkOutput("timeout_still_addr", bus.addr_phase, 1);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(3'b000, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    checkOutput("timeout_sticky", bus.err_timeout, 1);
    applyStimulus(3'b000, 3'b001, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("timeout_data_phase", bus.data_phase, 1);
    checkOutput("timeout_sticky_in_data", bus.err_timeout, 1);

    $display("[TB] reset during data phase");
    rstn = 1'b0;
    applyStimulus(3'b011, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("midreset_grant_valid", bus.grant_valid, 0);
    checkOutput("midreset_data_phase", bus.data_phase, 0);
    checkOutput("midreset_err_timeout", bus.err_timeout, 0);
    rstn = 1'b1;
    // Before reset ptr was 1, which would have picked master 1 here.
    simpleLock(3'b011, 3'b000, 1'b0, 2'd0);

    applyStimulus(3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("scoreboard_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
